// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed hex display scanner: one shared seven-segment decoder,
// tear-free frame-boundary updates, dead time and leading-zero blanking.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 50000,
  parameter int DEAD_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   dig_n,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         shadow;
  logic [DW-1:0]         disp;
  logic                  wrap_q;
  logic                  tick;
  logic                  wrap;
  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [6:0]            seg_d;
  logic [NUM_DIGITS-1:0] dig_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick = enable && (cnt == CW'(TICK_DIV - 1));
  assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      wrap_q <= 1'b0;
    end else if (!enable) begin
      cnt    <= '0;
      idx    <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt    <= tick ? '0 : cnt + 1'b1;
      wrap_q <= wrap;
      if (tick)
        idx <= wrap ? '0 : idx + 1'b1;
    end
  end

  // A load landing on the wrap edge bypasses the shadow straight to disp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else if (wrap && load) begin
      shadow  <= value_in;
      disp    <= value_in;
      pending <= 1'b0;
    end else if (wrap && pending) begin
      disp    <= shadow;
      pending <= 1'b0;
    end else if (load) begin
      shadow  <= value_in;
      pending <= 1'b1;
    end
  end

  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (disp[DW-1 -: 4] == 4'h0);
    for (int p = NUM_DIGITS - 2; p >= 0; p--)
      upper_zero[p] = upper_zero[p+1] && (disp[4*p +: 4] == 4'h0);
  end

  assign nib = disp[4*idx +: 4];

  always_comb begin
    seg_d = 7'h7F;
    dig_d = '1;
    if (enable && (cnt >= CW'(DEAD_CYC))) begin
      dig_d[idx] = 1'b0;
      if (!(blank_lz && (idx != '0) && upper_zero[idx]))
        seg_d = hex7(nib);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n      <= 7'h7F;
      dig_n      <= '1;
      frame_done <= 1'b0;
    end else begin
      seg_n      <= seg_d;
      dig_n      <= dig_d;
      frame_done <= enable && wrap_q;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: expected slot contents and
// frame_done times are queued up front; a negedge monitor checks them.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        enable = 1'b0;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        frame_done;
  logic        pending;

  int total = 0;
  int bad = 0;
  int pcount = 0;
  int base = 0;
  bit mon_on = 1'b0;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];
  int   fd_q[$];
  exp_t e;
  int   fd_t;
  logic lit;
  logic prev_lit = 1'b0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(4),
    .TICK_DIV(8),
    .DEAD_CYC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value_in(value_in),
    .load(load),
    .blank_lz(blank_lz),
    .enable(enable),
    .seg_n(seg_n),
    .dig_n(dig_n),
    .frame_done(frame_done),
    .pending(pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pcount++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic goto(input int t);
    while (pcount - base < t) @(negedge clk);
  endtask

  task automatic push_slot(input logic [3:0] d, input logic [6:0] s,
                           input logic p);
    exp_t x;
    x.dig  = d;
    x.seg  = s;
    x.pend = p;
    exp_q.push_back(x);
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] p);
    push_slot(4'hE, s0, p[0]);
    push_slot(4'hD, s1, p[1]);
    push_slot(4'hB, s2, p[2]);
    push_slot(4'h7, s3, p[3]);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      lit = (dig_n !== 4'hF);
      if (lit)
        chk("onehot", $countones(~dig_n), 1);
      if (lit && !prev_lit) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL slot: unexpected dig_n=%h seg_n=%h", dig_n, seg_n);
        end else begin
          e = exp_q.pop_front();
          chk("slot_dig", dig_n, e.dig);
          chk("slot_seg", seg_n, e.seg);
          chk("slot_pend", pending, e.pend);
        end
      end
      prev_lit = lit;
      if (frame_done === 1'b1) begin
        if (fd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL frame_done: unexpected at %0d", pcount - base);
        end else begin
          fd_t = fd_q.pop_front();
          chk("frame_done_time", pcount - base, fd_t);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1);
  end

  initial begin
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);
    push_frame(7'h00, 7'h08, 7'h24, 7'h79, 4'b0000);
    push_frame(7'h00, 7'h08, 7'h24, 7'h79, 4'b1110);
    push_frame(7'h79, 7'h79, 7'h79, 7'h79, 4'b1100);
    push_frame(7'h24, 7'h24, 7'h24, 7'h24, 4'b0000);
    push_frame(7'h30, 7'h30, 7'h30, 7'h30, 4'b1110);
    push_frame(7'h40, 7'h12, 7'h7F, 7'h7F, 4'b1110);
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1110);
    push_slot(4'hE, 7'h0E, 1'b0);
    push_slot(4'hD, 7'h19, 1'b0);
    push_slot(4'hB, 7'h46, 1'b0);
    push_slot(4'hE, 7'h0E, 1'b0);
    push_slot(4'hD, 7'h19, 1'b1);
    push_slot(4'hE, 7'h40, 1'b0);
    push_slot(4'hD, 7'h7F, 1'b0);
    for (int k = 0; k < 8; k++)
      fd_q.push_back(33 + 32 * k);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_seg", seg_n, 7'h7F);
      chk("idle_dig", dig_n, 4'hF);
      chk("idle_pend", pending, 1'b0);
      chk("idle_fd", frame_done, 1'b0);
    end
    value_in = 16'h12A8;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("load_disabled_pend", pending, 1'b1);

    mon_on = 1'b1;
    base = pcount;
    enable = 1'b1;
    goto(1);
    chk("dead0", dig_n, 4'hF);
    goto(2);
    chk("dead1", dig_n, 4'hF);
    goto(3);
    chk("first_lit", dig_n, 4'hE);

    goto(69);
    value_in = 16'h1111;
    load = 1'b1;
    goto(70);
    load = 1'b0;

    goto(112);
    value_in = 16'h2222;
    load = 1'b1;
    goto(113);
    load = 1'b0;

    goto(159);
    value_in = 16'h3333;
    load = 1'b1;
    goto(160);
    load = 1'b0;
    chk("swap_edge_pend", pending, 1'b0);

    goto(169);
    value_in = 16'h0050;
    load = 1'b1;
    blank_lz = 1'b1;
    goto(170);
    load = 1'b0;

    goto(199);
    value_in = 16'h0000;
    load = 1'b1;
    goto(200);
    load = 1'b0;

    goto(229);
    value_in = 16'h9C4F;
    load = 1'b1;
    goto(230);
    load = 1'b0;

    goto(276);
    chk("pre_drop_dig", dig_n, 4'hB);
    enable = 1'b0;
    goto(277);
    chk("drop_dig", dig_n, 4'hF);
    chk("drop_seg", seg_n, 7'h7F);
    chk("drop_fd", frame_done, 1'b0);

    goto(285);
    enable = 1'b1;
    goto(286);
    chk("reen_dead0", dig_n, 4'hF);
    goto(287);
    chk("reen_dead1", dig_n, 4'hF);
    goto(288);
    chk("reen_lit", dig_n, 4'hE);

    goto(290);
    value_in = 16'h0001;
    load = 1'b1;
    goto(291);
    load = 1'b0;

    goto(298);
    rst = 1'b1;
    #1;
    chk("rst_seg", seg_n, 7'h7F);
    chk("rst_dig", dig_n, 4'hF);
    chk("rst_pend", pending, 1'b0);
    chk("rst_fd", frame_done, 1'b0);
    goto(300);
    rst = 1'b0;
    goto(301);
    chk("post_rst_dead0", dig_n, 4'hF);
    goto(302);
    chk("post_rst_dead1", dig_n, 4'hF);
    goto(303);
    chk("post_rst_lit", dig_n, 4'hE);

    goto(314);
    chk("slots_left", exp_q.size(), 0);
    chk("fd_left", fd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller that shares a single hex-to-seven-segment decoder across NUM_DIGITS common-anode digits on the board display. It latches a packed hex value through a load strobe, applies it tear-free at frame boundaries, and steps through digit positions at a programmable slot rate. It generates active-low digit enables with anti-ghosting dead time and optional leading-zero blanking. It sits between the CPU debug/observation path (PC, register or memory word) and the display pins.

## Interface
- NUM_DIGITS, 8, number of digit positions scanned (2..8)
- TICK_DIV, 50000, clock cycles per digit slot (>= DEAD_CYC+2)
- DEAD_CYC, 2, cycles at start of each slot with all digits disabled
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- value_in  in  4*NUM_DIGITS  packed hex value; nibble p drives digit p (p=0 is least significant, rightmost)
- load  in  1  single-cycle strobe; captures value_in into shadow register
- blank_lz  in  1  1 = blank leading-zero digits; sampled every cycle
- enable  in  1  1 = scan running; 0 = display dark, counters held at 0
- seg_n  out  7  active-low segments, bit6=g … bit0=a
- dig_n  out  NUM_DIGITS  active-low digit enables, at most one low
- frame_done  out  1  one-cycle pulse when the digit index wraps to 0
- pending  out  1  shadow holds a value not yet displayed

## Operation
- Registers: cnt (0..TICK_DIV-1), idx (0..NUM_DIGITS-1), shadow, disp, pending, plus registered outputs.
- enable=1: cnt increments each cycle and wraps to 0 after TICK_DIV-1 (tick). On tick, idx increments and wraps NUM_DIGITS-1 -> 0.
- enable=0: cnt and idx synchronously cleared; shadow, disp and pending retained; load still honoured; seg_n=7'h7F, dig_n all ones, frame_done=0.
- load=1: shadow <= value_in, pending <= 1. A later load before a swap overwrites shadow; last value wins.
- Swap: on the tick where idx wraps to 0, disp <= shadow and pending <= 0 if pending=1. If load coincides with the swap edge, disp <= value_in directly and pending stays 0.
- Decode uses the team hex table for nibble disp[4*idx+3:4*idx]. Active-low, g..a codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- Blanking: with blank_lz=1, position p>0 is blanked (seg_n=7F, dig_n bit p still driven low) when nibbles p..NUM_DIGITS-1 of disp are all zero. Position 0 is never blanked.
- Dead time: for cnt < DEAD_CYC, dig_n is all ones and seg_n=7F. Otherwise dig_n[idx]=0 and seg_n carries the decoded or blanked code.

## Timing
- Reset values: seg_n=7'h7F, dig_n all ones, frame_done=0, pending=0; cnt=0, idx=0, shadow=0, disp=0.
- Outputs are registered and reflect (cnt, idx, disp) with 1-cycle latency. Slot length is exactly TICK_DIV cycles; frame length is NUM_DIGITS*TICK_DIV cycles.
- frame_done is asserted the cycle after the wrap edge, i.e. concurrent with the first registered-output cycle of slot 0.
- Load-to-display latency runs to the next frame wrap: at most NUM_DIGITS*TICK_DIV cycles, plus 1 output cycle, and never mid-frame.
- Deasserting enable mid-slot takes effect at the next edge: outputs go dark 1 cycle later. Re-enable restarts at idx=0, cnt=0, beginning with dead time.
- Reset asserted mid-frame forces all outputs to reset values immediately (asynchronously). Scanning resumes from idx=0 on the first edge after release.

## Test plan
Benches use NUM_DIGITS=4, TICK_DIV=8, DEAD_CYC=2.
- Reset/idle: release rst with enable=0 -> seg_n=7F, dig_n=4'hF, pending=0, frame_done=0 indefinitely.
- Basic scan: load 16'h12A8, enable=1 -> after the first wrap, each frame per slot shows 2 dark cycles then 6 cycles with dig_n=E/seg 00, D/08, B/24, 7/79; frame_done pulses every 32 cycles.
- Tear-free update: display 16'h1111, then load 16'h2222 at slot 2 -> slots 2..3 still show 79, pending=1; the next frame shows 24 on all digits and pending=0.
- Load on swap edge: load 16'h3333 exactly at the wrap edge -> that frame shows 30 on all digits, pending never rises.
- Leading-zero blanking: disp=16'h0050, blank_lz=1 -> digits 3 and 2 enabled with seg_n=7F, digit 1 shows 12, digit 0 shows 40. With disp=0, only digit 0 shows 40.
- Enable/reset mid-frame: drop enable in slot 2 -> dark next cycle; re-enable -> 2 dead cycles then digit 0. Pulse rst mid-slot -> immediate reset values, disp=0.
